id_ex_alu_driver: RTL and testbench

- ID/EX pipeline stage that drives the execute-stage ALU's op1, op2 and 4-bit alu_control inputs.
- Captures decoded operands and control from decode, and converts ALUOp/funct/opcode into the ALU operation encoding.
- Resolves EX/MEM and MEM/WB data hazards by forwarding.
- Supports pipeline stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_alu_driver.sv | 101 ++++++++++
 tb/tb_id_ex_alu_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_driver.sv
// id_ex_alu_driver: ID/EX stage register with ALU-control decode and EX/MEM, MEM/WB operand forwarding
module id_ex_alu_driver #(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [1:0]   id_alu_op,
  input  logic [5:0]   id_funct,
  input  logic [5:0]   id_opcode,
  input  logic         id_alu_src,
  input  logic [4:0]   id_rs_num,
  input  logic [4:0]   id_rt_num,
  input  logic [B-1:0] id_rs_data,
  input  logic [B-1:0] id_rt_data,
  input  logic [B-1:0] id_imm,
  input  logic         exmem_reg_write,
  input  logic [4:0]   exmem_rd_num,
  input  logic [B-1:0] exmem_result,
  input  logic         memwb_reg_write,
  input  logic [4:0]   memwb_rd_num,
  input  logic [B-1:0] memwb_result,
  output logic [B-1:0] op1,
  output logic [B-1:0] op2,
  output logic [3:0]   alu_control,
  output logic [B-1:0] ex_store_data,
  output logic         ex_valid
);
  logic         valid;
  logic [3:0]   ctrl;
  logic         alu_src;
  logic [4:0]   rs_num;
  logic [4:0]   rt_num;
  logic [B-1:0] rs_data;
  logic [B-1:0] rt_data;
  logic [B-1:0] imm;
  logic [3:0]   code;
  logic [B-1:0] fa;
  logic [B-1:0] fb;
  always_comb begin
    code = 4'hf;
    case (id_alu_op)
      2'b00: code = 4'h0;
      2'b01: code = 4'h1;
      2'b10:
        case (id_funct)
          6'b100000, 6'b100001: code = 4'h0;
          6'b100010, 6'b100011: code = 4'h1;
          6'b100100: code = 4'h2;
          6'b100101: code = 4'h3;
          6'b100110: code = 4'h4;
          6'b100111: code = 4'h5;
          6'b101010: code = 4'h6;
          default:   code = 4'hf;
        endcase
      default:
        case (id_opcode)
          6'b001000, 6'b001001: code = 4'h0;
          6'b001100: code = 4'h2;
          6'b001101: code = 4'h3;
          6'b001110: code = 4'h4;
          6'b001010: code = 4'h6;
          default:   code = 4'hf;
        endcase
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid   <= 1'b0;
      ctrl    <= '0;
      alu_src <= 1'b0;
      rs_num  <= '0;
      rt_num  <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm     <= '0;
    end else if (!stall) begin
      valid   <= id_valid;
      ctrl    <= code;
      alu_src <= id_alu_src;
      rs_num  <= id_rs_num;
      rt_num  <= id_rt_num;
      rs_data <= id_rs_data;
      rt_data <= id_rt_data;
      imm     <= id_imm;
    end
  end
  always_comb begin
    fa = (exmem_reg_write && |exmem_rd_num && exmem_rd_num == rs_num) ? exmem_result :
         (memwb_reg_write && |memwb_rd_num && memwb_rd_num == rs_num) ? memwb_result : rs_data;
    fb = (exmem_reg_write && |exmem_rd_num && exmem_rd_num == rt_num) ? exmem_result :
         (memwb_reg_write && |memwb_rd_num && memwb_rd_num == rt_num) ? memwb_result : rt_data;
  end
  assign ex_valid      = valid;
  assign op1           = valid ? fa : '0;
  assign op2           = valid ? (alu_src ? imm : fb) : '0;
  assign ex_store_data = valid ? fb : '0;
  assign alu_control   = valid ? ctrl : 4'h0;
endmodule

// File: tb/tb_id_ex_alu_driver.sv
// tb_id_ex_alu_driver: directed and randomized checks against a table-driven reference model
module tb_id_ex_alu_driver;
  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid, id_alu_src;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct, id_opcode;
  logic [4:0]  id_rs_num, id_rt_num, exmem_rd_num, memwb_rd_num;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] op1, op2, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] fmap[logic [5:0]];
  logic [3:0] omap[logic [5:0]];
  logic        m_v, m_src;
  logic [3:0]  m_c;
  logic [4:0]  m_rsn, m_rtn;
  logic [31:0] m_rsd, m_rtd, m_imm;
  id_ex_alu_driver #(.B(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_opcode(id_opcode), .id_alu_src(id_alu_src),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .exmem_reg_write(exmem_reg_write), .exmem_rd_num(exmem_rd_num),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd_num(memwb_rd_num),
    .memwb_result(memwb_result), .op1(op1), .op2(op2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] ref_code(logic [1:0] op, logic [5:0] f, logic [5:0] o);
    if (op == 2'd0) return 4'h0;
    if (op == 2'd1) return 4'h1;
    if (op == 2'd2) return fmap.exists(f) ? fmap[f] : 4'hf;
    return omap.exists(o) ? omap[o] : 4'hf;
  endfunction
  function automatic logic [31:0] ref_fwd(logic [4:0] n, logic [31:0] d);
    if (exmem_reg_write && exmem_rd_num != 0 && exmem_rd_num == n) return exmem_result;
    if (memwb_reg_write && memwb_rd_num != 0 && memwb_rd_num == n) return memwb_result;
    return d;
  endfunction
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  task automatic chk_all(input string t);
    logic [31:0] fa, fb;
    fa = ref_fwd(m_rsn, m_rsd);
    fb = ref_fwd(m_rtn, m_rtd);
    chk({t, ".valid"}, {31'd0, ex_valid}, {31'd0, m_v});
    chk({t, ".op1"}, op1, m_v ? fa : 32'd0);
    chk({t, ".op2"}, op2, m_v ? (m_src ? m_imm : fb) : 32'd0);
    chk({t, ".store"}, ex_store_data, m_v ? fb : 32'd0);
    chk({t, ".ctrl"}, {28'd0, alu_control}, {28'd0, m_v ? m_c : 4'h0});
  endtask
  task automatic tick;
    @(posedge clk);
    if (reset || flush) begin
      {m_v, m_src, m_c, m_rsn, m_rtn, m_rsd, m_rtd, m_imm} = '0;
    end else if (!stall) begin
      m_v = id_valid; m_src = id_alu_src; m_c = ref_code(id_alu_op, id_funct, id_opcode);
      m_rsn = id_rs_num; m_rtn = id_rt_num; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
    end
    #1;
  endtask
  task automatic rand_id;
    id_valid = 1'($urandom); id_alu_op = 2'($urandom); id_funct = 6'($urandom);
    id_opcode = 6'($urandom); id_alu_src = 1'($urandom);
    id_rs_num = 5'($urandom_range(0, 3)); id_rt_num = 5'($urandom_range(0, 3));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask
  task automatic rand_fwd;
    exmem_reg_write = 1'($urandom); exmem_rd_num = 5'($urandom_range(0, 3)); exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd_num = 5'($urandom_range(0, 3)); memwb_result = $urandom;
  endtask
  initial begin
    logic [5:0] fl[10];
    logic [5:0] ol[7];
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00};
    ol = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h3f};
    fmap[6'h20] = 4'h0; fmap[6'h21] = 4'h0; fmap[6'h22] = 4'h1; fmap[6'h23] = 4'h1;
    fmap[6'h24] = 4'h2; fmap[6'h25] = 4'h3; fmap[6'h26] = 4'h4; fmap[6'h27] = 4'h5; fmap[6'h2a] = 4'h6;
    omap[6'h08] = 4'h0; omap[6'h09] = 4'h0; omap[6'h0c] = 4'h2; omap[6'h0d] = 4'h3;
    omap[6'h0e] = 4'h4; omap[6'h0a] = 4'h6;
    {m_v, m_src, m_c, m_rsn, m_rtn, m_rsd, m_rtd, m_imm} = '0;
    reset = 1; stall = 0; flush = 0;
    rand_id; id_valid = 1;
    {exmem_reg_write, exmem_rd_num, exmem_result, memwb_reg_write, memwb_rd_num, memwb_result} = '0;
    tick; tick;
    chk("reset.valid", {31'd0, ex_valid}, 32'd0);
    chk("reset.op1", op1, 32'd0);
    chk("reset.op2", op2, 32'd0);
    chk("reset.ctrl", {28'd0, alu_control}, 32'd0);
    reset = 0; id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010; id_alu_src = 0;
    id_rs_num = 1; id_rt_num = 2; id_rs_data = 9; id_rt_data = 4;
    tick;
    chk("first.op1", op1, 32'd9);
    chk("first.op2", op2, 32'd4);
    chk("first.ctrl", {28'd0, alu_control}, 32'd1);
    chk("first.valid", {31'd0, ex_valid}, 32'd1);
    id_alu_op = 2'b10;
    for (int i = 0; i < 10; i++) begin id_funct = fl[i]; tick; chk_all("funct"); end
    id_alu_op = 2'b11;
    for (int i = 0; i < 7; i++) begin id_opcode = ol[i]; tick; chk_all("opcode"); end
    id_opcode = 6'h3f; tick;
    chk("opcode_unknown", {28'd0, alu_control}, 32'hf);
    id_alu_op = 2'b10; id_funct = 6'h00; tick;
    chk("funct_unknown", {28'd0, alu_control}, 32'hf);
    id_alu_op = 2'b00; tick; chk_all("aluop00");
    id_alu_op = 2'b01; tick; chk_all("aluop01");
    id_rs_num = 5; id_rs_data = 32'h1234; tick;
    exmem_reg_write = 1; exmem_rd_num = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd_num = 5; memwb_result = 32'hBBBB; #1;
    chk("fwd.exmem", op1, 32'hAAAA);
    exmem_reg_write = 0; #1;
    chk("fwd.memwb", op1, 32'hBBBB);
    exmem_reg_write = 1; exmem_rd_num = 0; memwb_rd_num = 0; #1;
    chk("fwd.r0", op1, 32'h1234);
    id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_rt_num = 3; tick;
    exmem_rd_num = 3; exmem_result = 32'h10; #1;
    chk("src.op2", op2, 32'hFFFFFFFC);
    chk("src.store", ex_store_data, 32'h10);
    id_valid = 1; id_alu_src = 0; tick; chk_all("capture");
    stall = 1;
    for (int i = 0; i < 3; i++) begin rand_id; rand_fwd; tick; chk_all("stall"); end
    flush = 1; tick;
    chk("flush.valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.op1", op1, 32'd0);
    chk_all("flush");
    flush = 0; stall = 0; id_valid = 0; id_rs_num = 2;
    exmem_reg_write = 1; exmem_rd_num = 2; exmem_result = 32'hDEAD; tick;
    chk("bubble.op1", op1, 32'd0);
    chk("bubble.op2", op2, 32'd0);
    chk("bubble.ctrl", {28'd0, alu_control}, 32'd0);
    id_valid = 1; tick; stall = 1; tick; reset = 1; tick;
    chk("reset_stall.valid", {31'd0, ex_valid}, 32'd0);
    reset = 0; stall = 0;
    for (int i = 0; i < 400; i++) begin
      rand_id; rand_fwd;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 29) == 0);
      tick;
      chk_all("random");
      rand_fwd; #1;
      chk_all("random_fwd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
